// File: rtl/counter_seq_ctrl_if.sv
// Configuration handshake between a host and counter_seq_ctrl: a terminal-count
// limit plus a one-shot/auto-reload mode bit, offered under valid/ready.
interface counter_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [WIDTH-1:0] cfg_limit;
  logic             cfg_reload;

  modport master (output cfg_valid, cfg_limit, cfg_reload, input cfg_ready);
  modport slave  (input cfg_valid, cfg_limit, cfg_reload, output cfg_ready);
endinterface

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for an external synchronous binary counter: arms, runs,
// pauses and terminates the count, in one-shot or auto-reload mode.
module counter_seq_ctrl #(
  parameter int WIDTH  = 4,
  parameter int PCNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  counter_seq_ctrl_if.slave  cfg,
  input  logic               start,
  input  logic               pause,
  input  logic               abort,
  input  logic [WIDTH-1:0]   cnt_q,
  output logic               cnt_en,
  output logic               cnt_clr,
  output logic               busy,
  output logic               done,
  output logic [PCNT_W-1:0]  period_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] limit_r;
  logic             reload_r;
  logic             tc;

  assign tc            = (cnt_q == limit_r);
  assign cfg.cfg_ready = (state == S_IDLE);

  // Counter commands depend on the live inputs so the counter reacts in the
  // same cycle that tc, pause or abort is seen.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cnt_en  = 1'b0;
    cnt_clr = 1'b0;
    unique case (state)
      S_ARMED: cnt_clr = 1'b1;
      S_RUN: begin
        if (abort)         cnt_clr = 1'b1;
        else if (tc)       cnt_clr = reload_r;
        else if (!pause)   cnt_en  = 1'b1;
      end
      S_PAUSE: cnt_clr = abort;
      default: ;
    endcase
  end

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      limit_r    <= '0;
      reload_r   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      period_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (cfg.cfg_valid) begin
            limit_r    <= cfg.cfg_limit;
            reload_r   <= cfg.cfg_reload;
            period_cnt <= '0;
            state      <= S_ARMED;
            busy       <= 1'b1;
          end
        end
        S_ARMED: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (start) begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (tc) begin
            done <= 1'b1;
            if (reload_r) begin
              if (period_cnt != '1) period_cnt <= period_cnt + PCNT_W'(1);
            end else begin
              state <= S_DONE;
            end
          end else if (pause) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: begin
          if (abort) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (start) begin
            state <= S_RUN;
          end
        end
        default: begin
          // DONE lasts exactly one cycle; done was raised on entry.
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl with a behavioural counter datapath;
// a second instance with a 2-bit period counter checks saturation.
module tb_counter_seq_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_en, cnt_clr, busy, done;
  logic [7:0]       period_cnt;
  logic             cnt_en2, cnt_clr2, busy2, done2;
  logic [1:0]       period_cnt2;

  int tests = 0;
  int failures = 0;

  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.WIDTH(WIDTH)) cfg ();
  counter_seq_ctrl_if #(.WIDTH(WIDTH)) cfg2 ();

  assign cfg2.cfg_valid  = cfg.cfg_valid;
  assign cfg2.cfg_limit  = cfg.cfg_limit;
  assign cfg2.cfg_reload = cfg.cfg_reload;

  counter_seq_ctrl #(.WIDTH(WIDTH), .PCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .cfg(cfg.slave), .start(start), .pause(pause),
    .abort(abort), .cnt_q(cnt_q), .cnt_en(cnt_en), .cnt_clr(cnt_clr),
    .busy(busy), .done(done), .period_cnt(period_cnt)
  );

  counter_seq_ctrl #(.WIDTH(WIDTH), .PCNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .cfg(cfg2.slave), .start(start), .pause(pause),
    .abort(abort), .cnt_q(cnt_q), .cnt_en(cnt_en2), .cnt_clr(cnt_clr2),
    .busy(busy2), .done(done2), .period_cnt(period_cnt2)
  );

  // External counter datapath: clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       cnt_q <= '0;
    else if (cnt_clr) cnt_q <= '0;
    else if (cnt_en)  cnt_q <= cnt_q + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer a configuration in IDLE; returns at the first negedge in ARMED.
  task automatic configure(input logic [WIDTH-1:0] lim, input logic rel);
    cfg.cfg_valid  = 1'b1;
    cfg.cfg_limit  = lim;
    cfg.cfg_reload = rel;
    @(negedge clk);
    cfg.cfg_valid  = 1'b0;
  endtask

  typedef struct {
    logic             valid;
    logic [WIDTH-1:0] lim;
    logic             rel, st, pa, ab;
    logic [WIDTH-1:0] q;
    logic             en, clr, bsy, dn, rdy;
    logic [7:0]       pc;
  } vec_t;

  vec_t vecs[17];

  initial begin
    // Auto-reload, limit 3: one cycle per row, outputs seen with that row's inputs.
    //            valid lim  rel  st   pa   ab    q   en   clr  bsy  dn   rdy  pc
    vecs[0]  = '{1'b1,4'd3,1'b1,1'b0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,1'b1,8'd0};
    vecs[1]  = '{1'b0,4'd0,1'b0,1'b1,1'b0,1'b0, 4'd0,1'b0,1'b1,1'b1,1'b0,1'b0,8'd0};
    vecs[2]  = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0};
    vecs[3]  = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0};
    vecs[4]  = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd2,1'b1,1'b0,1'b1,1'b0,1'b0,8'd0};
    vecs[5]  = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd3,1'b0,1'b1,1'b1,1'b0,1'b0,8'd0};
    vecs[6]  = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b1,1'b0,1'b1,1'b1,1'b0,8'd1};
    vecs[7]  = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd1};
    vecs[8]  = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd2,1'b1,1'b0,1'b1,1'b0,1'b0,8'd1};
    vecs[9]  = '{1'b0,4'd0,1'b0,1'b0,1'b1,1'b0, 4'd3,1'b0,1'b1,1'b1,1'b0,1'b0,8'd1};
    vecs[10] = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b1,1'b0,1'b1,1'b1,1'b0,8'd2};
    vecs[11] = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd1,1'b1,1'b0,1'b1,1'b0,1'b0,8'd2};
    vecs[12] = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd2,1'b1,1'b0,1'b1,1'b0,1'b0,8'd2};
    vecs[13] = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd3,1'b0,1'b1,1'b1,1'b0,1'b0,8'd2};
    vecs[14] = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b1,1'b0,1'b1,1'b1,1'b0,8'd3};
    vecs[15] = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b1, 4'd1,1'b0,1'b1,1'b1,1'b0,1'b0,8'd3};
    vecs[16] = '{1'b0,4'd0,1'b0,1'b0,1'b0,1'b0, 4'd0,1'b0,1'b0,1'b0,1'b0,1'b1,8'd3};

    cfg.cfg_valid = 1'b0; cfg.cfg_limit = '0; cfg.cfg_reload = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", cfg.cfg_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pcnt", period_cnt, 8'd0);
    check("rst_en", cnt_en, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: auto-reload limit 3, tc wins over pause, abort from RUN.
    for (int i = 0; i < 17; i++) begin
      cfg.cfg_valid  = vecs[i].valid;
      cfg.cfg_limit  = vecs[i].lim;
      cfg.cfg_reload = vecs[i].rel;
      start = vecs[i].st; pause = vecs[i].pa; abort = vecs[i].ab;
      #1;
      check($sformatf("vec%0d_q", i), cnt_q, vecs[i].q);
      if (!vecs[i].clr) check($sformatf("vec%0d_en", i), cnt_en, vecs[i].en);
      check($sformatf("vec%0d_clr", i), cnt_clr, vecs[i].clr);
      check($sformatf("vec%0d_busy", i), busy, vecs[i].bsy);
      check($sformatf("vec%0d_done", i), done, vecs[i].dn);
      check($sformatf("vec%0d_ready", i), cfg.cfg_ready, vecs[i].rdy);
      check($sformatf("vec%0d_pcnt", i), period_cnt, vecs[i].pc);
      @(negedge clk);
    end
    cfg.cfg_valid = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;

    // One-shot, limit 9: start at t, enable t+1..t+9, done at t+11, ready at t+12.
    configure(4'd9, 1'b0);
    start = 1'b1; #1;
    check("os9_armed_clr", cnt_clr, 1'b1);
    @(negedge clk); start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      #1;
      check($sformatf("os9_en_t%0d", i), cnt_en, 1'b1);
      check($sformatf("os9_q_t%0d", i), cnt_q, 32'(i - 1));
      @(negedge clk);
    end
    #1;
    check("os9_en_t10", cnt_en, 1'b0);
    check("os9_q_t10", cnt_q, 4'd9);
    check("os9_done_t10", done, 1'b0);
    @(negedge clk); #1;
    check("os9_done_t11", done, 1'b1);
    check("os9_q_t11", cnt_q, 4'd9);
    check("os9_ready_t11", cfg.cfg_ready, 1'b0);
    check("os9_en_t11", cnt_en, 1'b0);
    @(negedge clk); #1;
    check("os9_done_t12", done, 1'b0);
    check("os9_ready_t12", cfg.cfg_ready, 1'b1);
    check("os9_busy_t12", busy, 1'b0);
    check("os9_q_t12", cnt_q, 4'd9);
    @(negedge clk);

    // One-shot, limit 7, pause at q=2 for 4 cycles: done moves from t+9 to t+13.
    configure(4'd7, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2) @(negedge clk);
    pause = 1'b1; #1;
    check("pz_q_t3", cnt_q, 4'd2);
    check("pz_en_t3", cnt_en, 1'b0);
    @(negedge clk);
    for (int i = 4; i <= 6; i++) begin
      if (i == 6) start = 1'b1;
      #1;
      check($sformatf("pz_hold_q_t%0d", i), cnt_q, 4'd2);
      check($sformatf("pz_hold_en_t%0d", i), cnt_en, 1'b0);
      check($sformatf("pz_hold_clr_t%0d", i), cnt_clr, 1'b0);
      check($sformatf("pz_busy_t%0d", i), busy, 1'b1);
      @(negedge clk);
    end
    start = 1'b0; pause = 1'b0;
    for (int n = 7; n <= 13; n++) begin
      #1;
      check($sformatf("pz_done_t%0d", n), done, (n == 13) ? 1'b1 : 1'b0);
      if (n == 7)  check("pz_resume_q", cnt_q, 4'd2);
      if (n == 12) check("pz_tc_q", cnt_q, 4'd7);
      @(negedge clk);
    end
    #1;
    check("pz_ready", cfg.cfg_ready, 1'b1);
    @(negedge clk);

    // Abort in ARMED.
    configure(4'd5, 1'b0);
    abort = 1'b1; #1;
    check("ab_armed_clr", cnt_clr, 1'b1);
    @(negedge clk); abort = 1'b0; #1;
    check("ab_armed_ready", cfg.cfg_ready, 1'b1);
    check("ab_armed_busy", busy, 1'b0);
    check("ab_armed_done", done, 1'b0);
    @(negedge clk);

    // Abort in RUN at q=4.
    configure(4'd9, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1; #1;
    check("ab_run_q", cnt_q, 4'd4);
    check("ab_run_clr", cnt_clr, 1'b1);
    @(negedge clk); abort = 1'b0; #1;
    check("ab_run_idle_q", cnt_q, 4'd0);
    check("ab_run_ready", cfg.cfg_ready, 1'b1);
    check("ab_run_done", done, 1'b0);
    @(negedge clk); #1;
    check("ab_run_done2", done, 1'b0);
    @(negedge clk);

    // Abort in PAUSE.
    configure(4'd9, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); pause = 1'b1;
    @(negedge clk); pause = 1'b0;
    abort = 1'b1; #1;
    check("ab_pause_q", cnt_q, 4'd1);
    check("ab_pause_clr", cnt_clr, 1'b1);
    check("ab_pause_en", cnt_en, 1'b0);
    @(negedge clk); abort = 1'b0; #1;
    check("ab_pause_idle_q", cnt_q, 4'd0);
    check("ab_pause_ready", cfg.cfg_ready, 1'b1);
    check("ab_pause_done", done, 1'b0);
    @(negedge clk);

    // Limit 0, auto-reload for 6 RUN cycles: clr held, done every cycle, saturation.
    configure(4'd0, 1'b1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      #1;
      check($sformatf("l0r_clr_t%0d", n), cnt_clr, 1'b1);
      if (n >= 2) check($sformatf("l0r_done_t%0d", n), done, 1'b1);
      @(negedge clk);
    end
    #1;
    check("l0r_done_t7", done, 1'b1);
    check("l0r_pcnt8", period_cnt, 8'd6);
    check("l0r_pcnt2_sat", period_cnt2, 2'd3);
    abort = 1'b1; #1;
    check("l0r_abort_clr", cnt_clr, 1'b1);
    @(negedge clk); abort = 1'b0; #1;
    check("l0r_ready", cfg.cfg_ready, 1'b1);
    check("l0r_done_after", done, 1'b0);
    @(negedge clk);

    // Limit 0, one-shot: done two cycles after start.
    configure(4'd0, 1'b0);
    start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    check("l0o_done_t1", done, 1'b0);
    check("l0o_en_t1", cnt_en, 1'b0);
    @(negedge clk); #1;
    check("l0o_done_t2", done, 1'b1);
    check("l0o_busy_t2", busy, 1'b1);
    @(negedge clk); #1;
    check("l0o_ready_t3", cfg.cfg_ready, 1'b1);
    check("l0o_done_t3", done, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-RUN at q=5 with one reload period completed.
    configure(4'd5, 1'b1);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (11) @(negedge clk);
    #1;
    check("ar_q_before", cnt_q, 4'd5);
    check("ar_pcnt_before", period_cnt, 8'd1);
    #1 rst_n = 1'b0;
    #1;
    check("ar_busy", busy, 1'b0);
    check("ar_en", cnt_en, 1'b0);
    check("ar_ready", cfg.cfg_ready, 1'b1);
    check("ar_pcnt", period_cnt, 8'd0);
    check("ar_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
Sequencing controller for the team's synchronous binary counter datapath (the JK-flip-flop counter family). It accepts a terminal-count configuration through a valid/ready handshake. It then drives the counter's enable and clear lines through arm, run, pause and terminal phases, supporting one-shot and auto-reload modes. The counter itself stays external; this block only observes its count and commands it.

Parameters:
WIDTH, 4, bit width of the counter being controlled and of the limit value
PCNT_W, 8, width of the auto-reload period counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
cfg_valid  input  1  configuration offered
cfg_ready  output  1  controller can accept configuration
cfg_limit  input  WIDTH  terminal count value
cfg_reload  input  1  1 = auto-reload mode, 0 = one-shot
start  input  1  begin counting from ARMED, or resume from PAUSE
pause  input  1  hold the count while in RUN
abort  input  1  cancel the operation and return to IDLE
cnt_q  input  WIDTH  current count from the counter datapath
cnt_en  output  WIDTH-independent 1  counter increments by 1 at the next edge when high
cnt_clr  output  1  synchronous clear to the counter; has priority over cnt_en
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse marking terminal count
period_cnt  output  PCNT_W  number of completed auto-reload periods

Behaviour:
- Reset (rst_n low, asynchronous): state is IDLE; limit_r=0; reload_r=0; done=0; busy=0; period_cnt=0.
- cnt_en and cnt_clr are combinational from the state, the inputs, and tc = (cnt_q == limit_r).
- done, busy and period_cnt are registered.
- cfg_ready = (state==IDLE).
- Counter contract: on each edge, cnt_clr -> 0; else cnt_en -> cnt_q+1 (mod 2^WIDTH); else hold.
- FSM states are IDLE, ARMED, RUN, PAUSE and DONE. abort has the highest priority in every non-IDLE state.
  - IDLE:
    - cnt_en=0, cnt_clr=0.
    - If cfg_valid && cfg_ready: capture limit_r and reload_r, clear period_cnt, go to ARMED.
    - start, pause and abort are ignored in IDLE.
  - ARMED:
    - cnt_clr=1.
    - abort -> IDLE.
    - start -> RUN.
    - cfg_valid is ignored (cfg_ready=0).
  - RUN:
    - abort -> IDLE with cnt_clr=1 in that cycle.
    - Else if tc:
      - reload_r=1: cnt_clr=1, done=1 next cycle, period_cnt += 1 (saturates at all-ones), stay in RUN.
      - reload_r=0: cnt_en=0, go to DONE.
    - Else if pause: cnt_en=0, go to PAUSE.
    - Else: cnt_en=1.
    - tc takes priority over a simultaneous pause.
  - PAUSE:
    - cnt_en=0, cnt_clr=0; the count is held.
    - abort -> IDLE with cnt_clr=1.
    - start -> RUN. If start and pause are both high, go to RUN; pause is then sampled again in RUN.
  - DONE:
    - done=1 for exactly this one cycle; cnt_en=0; the count is held at limit_r.
    - Unconditionally go to IDLE next cycle.
- Latency (one-shot, limit L):
  - start is sampled in ARMED at cycle t.
  - RUN begins at t+1 with cnt_q=0.
  - cnt_q reaches L at t+1+L.
  - DONE and done=1 occur at t+2+L.
  - cfg_ready returns at t+3+L.
- Auto-reload timing: a period takes L+1 cycles. done pulses one cycle after each tc. Count sequence: 0..L, 0..L, ...
- limit 0 is legal:
  - tc holds immediately in RUN.
  - One-shot: DONE follows one cycle after RUN entry.
  - Reload: cnt_clr is held high continuously and done pulses every cycle.
- cnt_q values above limit_r are not expected, because the counter is cleared in ARMED. If one appears, the counter wraps through 2^WIDTH back to limit_r; no error flag is raised.
- Reset asserted mid-operation forces IDLE immediately. Outputs go to their reset values without waiting for a clock edge.

Test Plan:
- Reset with rst_n=0 mid-RUN at cnt_q=5 -> state IDLE, busy=0, cnt_en=0, cfg_ready=1 asynchronously; period_cnt=0.
- Config limit=9, reload=0; start at cycle t -> cnt_en high cycles t+1..t+9; done=1 only at t+11; count held at 9; cfg_ready=1 at t+12.
- Config limit=3, reload=1, run 14 cycles -> cnt_q sequence 0,1,2,3,0,1,2,3,...; done pulses every 4 cycles; period_cnt=3.
- Limit=7, one-shot; pause for 4 cycles at cnt_q=2, then start -> count holds at 2 during PAUSE; done is delayed by exactly 4 cycles.
- Abort in ARMED, RUN (cnt_q=4) and PAUSE -> IDLE next cycle; cnt_clr=1 in the abort cycle from RUN/PAUSE; no done pulse.
- limit=0, reload=1; PCNT_W=2 with limit=0 run for 6 cycles -> done pulses every cycle; period_cnt saturates at 3. One-shot with limit=0 -> done two cycles after start.
